pindex_rd_arbiter: RTL and testbench
====================================

# pindex_rd_arbiter

Round-robin read arbiter that shares the encoder's single pooling-index read port (`pindex_rd` / `pindex_rd_addr` / `pindex_out`) between several decoder unpooling requesters. It sits between one encoder block and its downstream decoder stages. It issues at most one SRAM read per cycle and tracks each read's owner through the fixed SRAM read latency. It returns each result to its requester with a one-hot valid.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..8)
- INDEX_ADDR_WIDTH, 14, pooling-index SRAM address width
- PINDEX_WIDTH, 2, pooling-index word width
- RD_LAT, 1, cycles from `pindex_rd` high to `pindex_in` valid (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req  in  N_REQ  per-requester read request; held until granted
- req_addr  in  N_REQ*INDEX_ADDR_WIDTH  per-requester address; requester i occupies bits [(i+1)*AW-1 : i*AW]
- rd_block  in  1  when high, no grant is issued (encoder reconfiguring index SRAM)
- gnt  out  N_REQ  one-hot grant; combinational, same cycle as accepted `req`
- pindex_rd  out  1  registered SRAM read strobe
- pindex_rd_addr  out  INDEX_ADDR_WIDTH  registered SRAM read address
- pindex_in  in  PINDEX_WIDTH  SRAM read data (encoder `pindex_out`)
- rsp_valid  out  N_REQ  one-hot response valid, registered
- rsp_data  out  PINDEX_WIDTH  response data, registered

## Operation
- Arbitration:
  - Round-robin pointer `ptr` is in range 0..N_REQ-1; reset value 0.
  - The winner is the first i with `req[i]`=1, searching ptr, ptr+1, … mod N_REQ.
  - `gnt` is all-zero if `rd_block`=1, `rst`=1, or no req is set.
  - On a grant to i, `ptr` ← (i+1) mod N_REQ on the next edge. Otherwise `ptr` holds.
- Handshake:
  - A request is accepted in the cycle `req[i]` & `gnt[i]`.
  - The requester deasserts or changes `req_addr` only after acceptance.
  - A requester holding `req` high continuously is re-granted only after every other active requester has been served once.
- Issue stage (registered):
  - `pindex_rd` ← |gnt.
  - `pindex_rd_addr` ← winner's address. It holds its last value when `pindex_rd` is 0.
- Tag pipeline:
  - A shift register of depth RD_LAT carries a one-hot owner tag, all-zero when there is no read.
  - Stage 0 loads a copy of `gnt` delayed one cycle, aligned with `pindex_rd`.
  - When the tag exits the last stage, `pindex_in` is valid. On that edge, `rsp_valid` ← tag and `rsp_data` ← `pindex_in`.
  - If the exiting tag is zero, `rsp_valid` ← 0 and `rsp_data` holds.
- Back-to-back reads are fully pipelined: one grant per cycle sustained, with no bubbles between different or the same requesters.
- There are no outstanding-request limits and no response back-pressure. Requesters must accept `rsp_valid` unconditionally.

## Timing
- Reset values (after any cycle with `rst`=1): `ptr`=0; `pindex_rd`=0; `pindex_rd_addr`=0; all tag stages 0; `rsp_valid`=0; `rsp_data`=0. `gnt`=0 while `rst` is high.
- Latency, for a request accepted in cycle t:
  - `pindex_rd` is high in t+1.
  - `pindex_in` is sampled at the end of cycle t+RD_LAT.
  - `rsp_valid` and `rsp_data` are high/valid in cycle t+1+RD_LAT. With RD_LAT=1 this is t+2.
- Reset mid-operation: all in-flight tags are discarded. No `rsp_valid` is produced for reads issued before reset, even if `pindex_in` later changes.
- `rd_block` rising in cycle t:
  - No grant is issued in t.
  - Reads already issued complete and respond normally.
  - `ptr` is unchanged while blocked.
- Simultaneous events:
  - A new grant and a response in the same cycle are independent.
  - A requester may be granted in the same cycle its earlier response is returned.
- Wrap-around: `ptr` at N_REQ-1 followed by a grant to N_REQ-1 gives `ptr`=0.
- N_REQ=1: `gnt`=`req`&~`rd_block`, and `ptr` stays 0.

## Test plan
- Reset then single read, N_REQ=2, RD_LAT=1:
  - Stimulus: req=01, addr0=0x0123; SRAM model returns addr[1:0]+1.
  - Required: gnt=01 at t; pindex_rd=1 with addr 0x0123 at t+1; rsp_valid=01 with rsp_data=0 at t+2 (0x0123[1:0]=3, 3+1 wraps to 0 in 2 bits).
- Both requesters requesting continuously for 6 cycles from reset:
  - Required: gnt sequence 01,10,01,10,01,10.
  - Required: six back-to-back pindex_rd pulses.
  - Required: rsp_valid sequence 01,10,01,10,01,10, offset by 2 cycles.
- N_REQ=4, req=1010 with ptr=3:
  - Required: grant 1000 first, then 0010, then 1000.
  - Required: ptr values 0, 2, 0 after each grant.
- rd_block high for 3 cycles while req=11:
  - Required: gnt=00 and pindex_rd=0 during the block.
  - Required: a response issued the cycle before the block still arrives.
  - Required: arbitration resumes from the unchanged ptr.
- RD_LAT=3, reads issued at t and t+1:
  - Required: rsp_valid at t+4 and t+5 with the correct one-hot tags and data.
  - Required: rst asserted at t+2 suppresses both responses, and all outputs read 0 at t+3.

Source files
------------

// File: rtl/pindex_rd_arbiter_if.sv
// Requester-side bus of the pooling-index read arbiter: per-requester
// request/address in, one-hot grant and one-hot response back out.
interface pindex_rd_arbiter_if #(
  parameter int N_REQ            = 2,
  parameter int INDEX_ADDR_WIDTH = 14,
  parameter int PINDEX_WIDTH     = 2
);
  logic [N_REQ-1:0]                  req;
  logic [N_REQ*INDEX_ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ-1:0]                  gnt;
  logic [N_REQ-1:0]                  rsp_valid;
  logic [PINDEX_WIDTH-1:0]           rsp_data;

  // Requester (decoder unpooling stage) view
  modport master (
    output req, req_addr,
    input  gnt, rsp_valid, rsp_data
  );

  // Arbiter view
  modport slave (
    input  req, req_addr,
    output gnt, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pindex_rd_arbiter.sv
// Round-robin arbiter sharing the encoder's single pooling-index SRAM read
// port between N_REQ decoder requesters. One read issued per cycle; the
// owner of each read rides a one-hot tag pipeline matched to the SRAM read
// latency and comes back as a one-hot rsp_valid.
module pindex_rd_arbiter #(
  parameter int N_REQ            = 2,
  parameter int INDEX_ADDR_WIDTH = 14,
  parameter int PINDEX_WIDTH     = 2,
  parameter int RD_LAT           = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_block,
  pindex_rd_arbiter_if.slave          rq,
  output logic                        pindex_rd,
  output logic [INDEX_ADDR_WIDTH-1:0] pindex_rd_addr,
  input  logic [PINDEX_WIDTH-1:0]     pindex_in
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Arbitration state
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win;
  logic             found;
  logic [N_REQ-1:0] gnt_c;
  logic [INDEX_ADDR_WIDTH-1:0] win_addr;

  // Issue stage
  logic                        rd_q, rd_d;
  logic [INDEX_ADDR_WIDTH-1:0] addr_q, addr_d;

  // Owner tag pipeline; stage 0 is aligned with pindex_rd
  logic [RD_LAT-1:0][N_REQ-1:0] tag_q, tag_d;
  logic [N_REQ-1:0]             tag_exit;

  // Response stage
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [PINDEX_WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Winner search: first pass takes the lowest requester at or above ptr,
  // second pass wraps to the lowest requester below ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rq.req[k] && (PTR_W'(k) >= ptr_q)) begin
        found = 1'b1;
        win   = PTR_W'(k);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rq.req[k]) begin
        found = 1'b1;
        win   = PTR_W'(k);
      end
    end
    // Reset and SRAM reconfiguration both suppress any grant
    if (rst || rd_block) found = 1'b0;
  end

  // One-hot grant and winner address mux
  always_comb begin
    gnt_c    = '0;
    win_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      gnt_c[k] = found && (win == PTR_W'(k));
      if (win == PTR_W'(k))
        win_addr = rq.req_addr[k*INDEX_ADDR_WIDTH +: INDEX_ADDR_WIDTH];
    end
  end

  assign rq.gnt = gnt_c;

  // Pointer advances past the winner; holds when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    if (found)
      ptr_d = (win == PTR_W'(N_REQ-1)) ? '0 : win + PTR_W'(1);
  end

  // Issue stage: strobe follows any grant, address holds between reads
  always_comb begin
    rd_d   = |gnt_c;
    addr_d = (|gnt_c) ? win_addr : addr_q;
  end

  // Tag shift register: the grant enters stage 0, shifts one stage per cycle
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = gnt_c;
    for (int s = 1; s < RD_LAT; s++)
      tag_d[s] = tag_q[s-1];
    tag_exit = tag_q[RD_LAT-1];
  end

  // Response capture: SRAM data is valid exactly when a tag leaves the pipe
  always_comb begin
    rsp_valid_d = tag_exit;
    rsp_data_d  = (|tag_exit) ? pindex_in : rsp_data_q;
  end

  // All state registers; reset discards in-flight tags
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign pindex_rd      = rd_q;
  assign pindex_rd_addr = addr_q;
  assign rq.rsp_valid   = rsp_valid_q;
  assign rq.rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_pindex_rd_arbiter.sv
// Directed bench: three arbiter configurations (N=2/LAT=1, N=4/LAT=1,
// N=2/LAT=3) on a shared clock, each with a small SRAM model that returns
// addr[1:0]+1 after the configured read latency.
module tb_pindex_rd_arbiter;
  localparam int AW = 14;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: N_REQ=2, RD_LAT=1
  logic          rst_a = 1'b1, blk_a = 1'b0, rd_a;
  logic [AW-1:0] rd_addr_a;
  logic [PW-1:0] pin_a;
  pindex_rd_arbiter_if #(.N_REQ(2), .INDEX_ADDR_WIDTH(AW), .PINDEX_WIDTH(PW)) if_a ();
  pindex_rd_arbiter #(.N_REQ(2), .INDEX_ADDR_WIDTH(AW), .PINDEX_WIDTH(PW), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .rd_block(blk_a), .rq(if_a),
    .pindex_rd(rd_a), .pindex_rd_addr(rd_addr_a), .pindex_in(pin_a));
  assign pin_a = rd_addr_a[1:0] + 2'd1;

  // Instance B: N_REQ=4, RD_LAT=1
  logic          rst_b = 1'b1, blk_b = 1'b0, rd_b;
  logic [AW-1:0] rd_addr_b;
  logic [PW-1:0] pin_b;
  pindex_rd_arbiter_if #(.N_REQ(4), .INDEX_ADDR_WIDTH(AW), .PINDEX_WIDTH(PW)) if_b ();
  pindex_rd_arbiter #(.N_REQ(4), .INDEX_ADDR_WIDTH(AW), .PINDEX_WIDTH(PW), .RD_LAT(1)) dut_b (
    .clk(clk), .rst(rst_b), .rd_block(blk_b), .rq(if_b),
    .pindex_rd(rd_b), .pindex_rd_addr(rd_addr_b), .pindex_in(pin_b));
  assign pin_b = rd_addr_b[1:0] + 2'd1;

  // Instance C: N_REQ=2, RD_LAT=3 (SRAM model delays data two extra cycles)
  logic          rst_c = 1'b1, blk_c = 1'b0, rd_c;
  logic [AW-1:0] rd_addr_c;
  logic [PW-1:0] pin_c, d1_c, d2_c;
  pindex_rd_arbiter_if #(.N_REQ(2), .INDEX_ADDR_WIDTH(AW), .PINDEX_WIDTH(PW)) if_c ();
  pindex_rd_arbiter #(.N_REQ(2), .INDEX_ADDR_WIDTH(AW), .PINDEX_WIDTH(PW), .RD_LAT(3)) dut_c (
    .clk(clk), .rst(rst_c), .rd_block(blk_c), .rq(if_c),
    .pindex_rd(rd_c), .pindex_rd_addr(rd_addr_c), .pindex_in(pin_c));
  always @(posedge clk) begin
    d1_c <= rd_addr_c[1:0] + 2'd1;
    d2_c <= d1_c;
  end
  assign pin_c = d2_c;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    tick(); rst_a = 1'b1; if_a.req = '0;
    tick(); rst_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.req = 2'b01; if_a.req_addr = {14'h0000, 14'h0123};
    tick(); #1;
    n_vec++; if (if_a.gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", if_a.gnt); end
    tick(); rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; if_a.req = '0; #1;
    n_vec++; if (rd_a !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", rd_a); end
    n_vec++; if (rd_addr_a !== 14'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", rd_addr_a); end
    n_vec++; if (if_a.rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 00", if_a.rsp_valid); end
    n_vec++; if (if_a.rsp_data !== 2'b00) begin n_err++; $display("FAIL reset_rsp_data: got %b want 00", if_a.rsp_data); end
    n_vec++; if (dut_a.ptr_q !== 1'b0) begin n_err++; $display("FAIL reset_ptr: got %0d want 0", dut_a.ptr_q); end
  endtask

  task automatic test_single_read();
    tick(); if_a.req = 2'b01; if_a.req_addr = {14'h0000, 14'h0123}; #1;
    n_vec++; if (if_a.gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b want 01", if_a.gnt); end
    tick(); if_a.req = 2'b00; #1;
    n_vec++; if (rd_a !== 1'b1) begin n_err++; $display("FAIL single_rd: got %b want 1", rd_a); end
    n_vec++; if (rd_addr_a !== 14'h0123) begin n_err++; $display("FAIL single_addr: got %h want 0123", rd_addr_a); end
    tick(); #1;
    n_vec++; if (if_a.rsp_valid !== 2'b01) begin n_err++; $display("FAIL single_rsp_valid: got %b want 01", if_a.rsp_valid); end
    n_vec++; if (if_a.rsp_data !== 2'd0) begin n_err++; $display("FAIL single_rsp_data: got %0d want 0", if_a.rsp_data); end
    tick(); #1;
    n_vec++; if (if_a.rsp_valid !== 2'b00) begin n_err++; $display("FAIL single_rsp_end: got %b want 00", if_a.rsp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    exp_g, exp_rv, exp_d;
    logic          exp_rd;
    logic [AW-1:0] exp_addr;
    reset_a();
    if_a.req_addr = {14'h0021, 14'h0010};
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      if_a.req = (c < 6) ? 2'b11 : 2'b00;
      #1;
      exp_g    = (c < 6) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rd   = (c >= 1 && c <= 6);
      exp_addr = ((c - 1) % 2 == 0) ? 14'h0010 : 14'h0021;
      exp_rv   = (c >= 2) ? (((c - 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_d    = ((c - 2) % 2 == 0) ? 2'd1 : 2'd2;
      n_vec++; if (if_a.gnt !== exp_g) begin n_err++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, if_a.gnt, exp_g); end
      n_vec++; if (rd_a !== exp_rd) begin n_err++; $display("FAIL b2b_rd c%0d: got %b want %b", c, rd_a, exp_rd); end
      if (exp_rd) begin
        n_vec++; if (rd_addr_a !== exp_addr) begin n_err++; $display("FAIL b2b_addr c%0d: got %h want %h", c, rd_addr_a, exp_addr); end
      end
      n_vec++; if (if_a.rsp_valid !== exp_rv) begin n_err++; $display("FAIL b2b_rsp_valid c%0d: got %b want %b", c, if_a.rsp_valid, exp_rv); end
      if (c >= 2) begin
        n_vec++; if (if_a.rsp_data !== exp_d) begin n_err++; $display("FAIL b2b_rsp_data c%0d: got %0d want %0d", c, if_a.rsp_data, exp_d); end
      end
    end
  endtask

  task automatic test_wrap_n4();
    if_b.req_addr = {14'h0333, 14'h0222, 14'h0111, 14'h0000};
    tick(); rst_b = 1'b1; if_b.req = '0;
    tick(); rst_b = 1'b0; if_b.req = 4'b0100; #1;
    n_vec++; if (if_b.gnt !== 4'b0100) begin n_err++; $display("FAIL n4_gnt_setup: got %b want 0100", if_b.gnt); end
    tick(); if_b.req = 4'b1010; #1;
    n_vec++; if (dut_b.ptr_q !== 2'd3) begin n_err++; $display("FAIL n4_ptr_setup: got %0d want 3", dut_b.ptr_q); end
    n_vec++; if (if_b.gnt !== 4'b1000) begin n_err++; $display("FAIL n4_gnt1: got %b want 1000", if_b.gnt); end
    tick(); #1;
    n_vec++; if (dut_b.ptr_q !== 2'd0) begin n_err++; $display("FAIL n4_ptr1: got %0d want 0", dut_b.ptr_q); end
    n_vec++; if (if_b.gnt !== 4'b0010) begin n_err++; $display("FAIL n4_gnt2: got %b want 0010", if_b.gnt); end
    n_vec++; if (rd_addr_b !== 14'h0333) begin n_err++; $display("FAIL n4_addr1: got %h want 0333", rd_addr_b); end
    tick(); #1;
    n_vec++; if (dut_b.ptr_q !== 2'd2) begin n_err++; $display("FAIL n4_ptr2: got %0d want 2", dut_b.ptr_q); end
    n_vec++; if (if_b.gnt !== 4'b1000) begin n_err++; $display("FAIL n4_gnt3: got %b want 1000", if_b.gnt); end
    n_vec++; if (rd_addr_b !== 14'h0111) begin n_err++; $display("FAIL n4_addr2: got %h want 0111", rd_addr_b); end
    tick(); if_b.req = '0; #1;
    n_vec++; if (dut_b.ptr_q !== 2'd0) begin n_err++; $display("FAIL n4_ptr3: got %0d want 0", dut_b.ptr_q); end
    n_vec++; if (if_b.rsp_valid !== 4'b0010) begin n_err++; $display("FAIL n4_rsp_valid: got %b want 0010", if_b.rsp_valid); end
    n_vec++; if (if_b.rsp_data !== 2'd2) begin n_err++; $display("FAIL n4_rsp_data: got %0d want 2", if_b.rsp_data); end
  endtask

  task automatic test_rd_block();
    reset_a();
    if_a.req_addr = {14'h0005, 14'h0042};
    if_a.req = 2'b11; blk_a = 1'b0; #1;
    n_vec++; if (if_a.gnt !== 2'b01) begin n_err++; $display("FAIL blk_gnt_pre: got %b want 01", if_a.gnt); end
    for (int c = 1; c <= 3; c++) begin
      tick(); blk_a = 1'b1; #1;
      n_vec++; if (if_a.gnt !== 2'b00) begin n_err++; $display("FAIL blk_gnt c%0d: got %b want 00", c, if_a.gnt); end
      n_vec++; if (rd_a !== (c == 1)) begin n_err++; $display("FAIL blk_rd c%0d: got %b want %b", c, rd_a, (c == 1)); end
      n_vec++; if (if_a.rsp_valid !== ((c == 2) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL blk_rsp_valid c%0d: got %b", c, if_a.rsp_valid); end
    end
    n_vec++; if (if_a.rsp_data !== 2'd3) begin n_err++; $display("FAIL blk_rsp_data: got %0d want 3", if_a.rsp_data); end
    n_vec++; if (dut_a.ptr_q !== 1'b1) begin n_err++; $display("FAIL blk_ptr: got %0d want 1", dut_a.ptr_q); end
    tick(); blk_a = 1'b0; #1;
    n_vec++; if (if_a.gnt !== 2'b10) begin n_err++; $display("FAIL blk_resume1: got %b want 10", if_a.gnt); end
    tick(); #1;
    n_vec++; if (if_a.gnt !== 2'b01) begin n_err++; $display("FAIL blk_resume2: got %b want 01", if_a.gnt); end
    tick(); if_a.req = 2'b00;
  endtask

  task automatic test_rdlat3();
    if_c.req_addr = {14'h0002, 14'h0001};
    tick(); rst_c = 1'b1; if_c.req = '0;
    tick(); rst_c = 1'b0; if_c.req = 2'b01; #1;
    n_vec++; if (if_c.gnt !== 2'b01) begin n_err++; $display("FAIL lat3_gnt0: got %b want 01", if_c.gnt); end
    tick(); if_c.req = 2'b10; #1;
    n_vec++; if (if_c.gnt !== 2'b10) begin n_err++; $display("FAIL lat3_gnt1: got %b want 10", if_c.gnt); end
    for (int c = 2; c <= 6; c++) begin
      tick(); if_c.req = 2'b00; #1;
      if (c == 2) begin
        n_vec++; if (rd_c !== 1'b1 || rd_addr_c !== 14'h0002) begin n_err++; $display("FAIL lat3_issue: got rd=%b addr=%h want 1/0002", rd_c, rd_addr_c); end
      end
      n_vec++; if (if_c.rsp_valid !== ((c == 4) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL lat3_rsp_valid t+%0d: got %b", c, if_c.rsp_valid); end
      if (c == 4 || c == 5) begin
        n_vec++; if (if_c.rsp_data !== ((c == 4) ? 2'd2 : 2'd3)) begin n_err++; $display("FAIL lat3_rsp_data t+%0d: got %0d", c, if_c.rsp_data); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    tick(); if_c.req = 2'b01; #1;
    n_vec++; if (if_c.gnt !== 2'b01) begin n_err++; $display("FAIL mid_gnt0: got %b want 01", if_c.gnt); end
    tick(); if_c.req = 2'b10; #1;
    n_vec++; if (if_c.gnt !== 2'b10) begin n_err++; $display("FAIL mid_gnt1: got %b want 10", if_c.gnt); end
    tick(); if_c.req = 2'b11; rst_c = 1'b1; #1;
    n_vec++; if (if_c.gnt !== 2'b00) begin n_err++; $display("FAIL mid_gnt_rst: got %b want 00", if_c.gnt); end
    tick(); if_c.req = 2'b00; rst_c = 1'b0; #1;
    n_vec++; if (rd_c !== 1'b0 || rd_addr_c !== 14'h0) begin n_err++; $display("FAIL mid_issue_clr: got rd=%b addr=%h want 0/0", rd_c, rd_addr_c); end
    n_vec++; if (if_c.rsp_valid !== 2'b00 || if_c.rsp_data !== 2'd0) begin n_err++; $display("FAIL mid_rsp_clr: got v=%b d=%0d want 00/0", if_c.rsp_valid, if_c.rsp_data); end
    n_vec++; if (if_c.gnt !== 2'b00) begin n_err++; $display("FAIL mid_gnt_t3: got %b want 00", if_c.gnt); end
    for (int c = 4; c <= 5; c++) begin
      tick(); #1;
      n_vec++; if (if_c.rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rsp_suppressed t+%0d: got %b want 00", c, if_c.rsp_valid); end
    end
  endtask

  initial begin
    if_a.req = '0; if_a.req_addr = '0;
    if_b.req = '0; if_b.req_addr = '0;
    if_c.req = '0; if_c.req_addr = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wrap_n4();
    test_rd_block();
    test_rdlat3();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
